// File: rtl/diy_recorder_if.sv
// diy_recorder_if: capture controls and packed chart outputs of the DIY recorder.
// The undo strobe exists only when DIY_UNDO_EN is defined.
interface diy_recorder_if;
   logic          record_start;
   logic          record_stop;
   logic [22:0]   music_address;
   logic [8:0]    hole_buttons;
`ifdef DIY_UNDO_EN
   logic          undo;
`endif
   logic [119:0]  diy_addresses;
   logic [19:0]   diy_locations;
   logic [2:0]    diy_count;
   logic          recording;
   logic          diy_ready;

   // master drives the recorder controls and reads back the chart
   modport master (
`ifdef DIY_UNDO_EN
      output undo,
`endif
      output record_start, record_stop, music_address, hole_buttons,
      input  diy_addresses, diy_locations, diy_count, recording, diy_ready
   );

   // slave is the recorder itself
   modport slave (
`ifdef DIY_UNDO_EN
      input  undo,
`endif
      input  record_start, record_stop, music_address, hole_buttons,
      output diy_addresses, diy_locations, diy_count, recording, diy_ready
   );
endinterface

// File: rtl/diy_recorder.sv
// diy_recorder: records hole-button taps as (music_address, hole) pairs into a
// 5-entry chart for mole to play back. Unused slots always read FFFFFF / F so
// mole never fires on them.
// Optional feature: DIY_UNDO_EN adds an undo strobe that removes the newest entry.
module diy_recorder #(
   parameter logic [22:0] MIN_GAP = 23'd2048
) (
   input  logic        clk,
   input  logic        reset,
   diy_recorder_if.slave bus
);

   localparam int          NUM_ENTRIES = 5;
   localparam int          NUM_HOLES   = 9;
   localparam logic [2:0]  LAST_SLOT   = 3'(NUM_ENTRIES - 1);
   localparam logic [23:0] EMPTY_ADDR  = 24'hFFFFFF;
   localparam logic [3:0]  EMPTY_LOC   = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             count_q, count_d;
   logic [NUM_HOLES-1:0]   btn_q, btn_d;
   logic [23:0]            addr_q [NUM_ENTRIES];
   logic [23:0]            addr_d [NUM_ENTRIES];
   logic [3:0]             loc_q  [NUM_ENTRIES];
   logic [3:0]             loc_d  [NUM_ENTRIES];

   logic [NUM_HOLES-1:0]   rise;
   logic                   hit;
   logic [3:0]             hole_idx;
   logic                   has_last;
   logic [2:0]             last_slot;
   logic [22:0]            last_addr;
   logic [22:0]            delta;
   logic                   wrap;
   logic                   gap_ok;
   logic                   undo_req;

`ifdef DIY_UNDO_EN
   assign undo_req = bus.undo;
`else
   assign undo_req = 1'b0;
`endif

   // next-state, chart update and tap detection
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      btn_d   = bus.hole_buttons;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         addr_d[i] = addr_q[i];
         loc_d[i]  = loc_q[i];
      end

      // lowest-index newly pressed hole wins; simultaneous others are dropped
      rise     = bus.hole_buttons & ~btn_q;
      hit      = 1'b0;
      hole_idx = 4'd0;
      for (int i = NUM_HOLES - 1; i >= 0; i--) begin
         if (rise[i]) begin
            hit      = 1'b1;
            hole_idx = 4'(i);
         end
      end

      // the newest stored entry is the reference for both wrap and gap checks
      has_last  = (count_q != 3'd0);
      last_slot = has_last ? (count_q - 3'd1) : 3'd0;
      last_addr = addr_q[last_slot][22:0];
      delta     = bus.music_address - last_addr;
      wrap      = has_last && (bus.music_address < last_addr);
      gap_ok    = !has_last || (delta >= MIN_GAP);

      if (bus.record_start) begin
         state_d = REC;
         count_d = 3'd0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_d[i] = EMPTY_ADDR;
            loc_d[i]  = EMPTY_LOC;
         end
      end else if (state_q == REC) begin
         if (bus.record_stop || wrap) begin
            state_d = DONE;
         end else if (hit && gap_ok) begin
            addr_d[count_q] = {1'b0, bus.music_address};
            loc_d[count_q]  = hole_idx;
            count_d         = count_q + 3'd1;
            if (count_q == LAST_SLOT) begin
               state_d = DONE;
            end
         end else if (undo_req && has_last) begin
            addr_d[last_slot] = EMPTY_ADDR;
            loc_d[last_slot]  = EMPTY_LOC;
            count_d           = count_q - 3'd1;
         end
      end
   end

   // state, chart and button history registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= 3'd0;
         btn_q   <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_q[i] <= EMPTY_ADDR;
            loc_q[i]  <= EMPTY_LOC;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         btn_q   <= btn_d;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_q[i] <= addr_d[i];
            loc_q[i]  <= loc_d[i];
         end
      end
   end

   // pack the chart onto the flat buses read by mole
   always_comb begin
      bus.diy_addresses = '0;
      bus.diy_locations = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         bus.diy_addresses[24*i +: 24] = addr_q[i];
         bus.diy_locations[4*i +: 4]   = loc_q[i];
      end
      bus.diy_count = count_q;
      bus.recording = (state_q == REC);
      bus.diy_ready = (state_q == DONE) && (count_q != 3'd0);
   end

endmodule

// File: tb/tb_diy_recorder.sv
// tb_diy_recorder: directed vectors with hand-computed expected charts.
module tb_diy_recorder;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   localparam logic [119:0] ALL_F_ADDR = {5{24'hFFFFFF}};
   localparam logic [119:0] ALL_F_LOC  = 120'(20'hFFFFF);

   diy_recorder_if bus ();

   diy_recorder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.record_start = 1'b1;
      tick();
      bus.record_start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.record_stop = 1'b1;
      tick();
      bus.record_stop = 1'b0;
   endtask

   // press one hole at the given address for a cycle, then release it
   task automatic tap(input int hole, input logic [22:0] addr);
      bus.music_address = addr;
      bus.hole_buttons  = 9'(1 << hole);
      tick();
      bus.hole_buttons  = 9'd0;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.record_start  = 1'b0;
      bus.record_stop   = 1'b0;
      bus.music_address = 23'd0;
      bus.hole_buttons  = 9'd0;
`ifdef DIY_UNDO_EN
      bus.undo = 1'b0;
`endif
      tick();
      tick();

      // 1: reset state
      check("rst_addr",  bus.diy_addresses, ALL_F_ADDR);
      check("rst_loc",   120'(bus.diy_locations), ALL_F_LOC);
      check("rst_count", 120'(bus.diy_count), 120'd0);
      check("rst_ready", 120'(bus.diy_ready), 120'd0);
      check("rst_rec",   120'(bus.recording), 120'd0);
      reset = 1'b0;
      tick();

      // 2: two taps then stop
      pulse_start();
      check("t2_rec", 120'(bus.recording), 120'd1);
      tap(2, 23'h006CDE);
      tap(7, 23'h008B00);
      pulse_stop();
      check("t2_addr",  bus.diy_addresses,
            {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h008B00, 24'h006CDE});
      check("t2_loc",   120'(bus.diy_locations), 120'(20'hFFF72));
      check("t2_count", 120'(bus.diy_count), 120'd2);
      check("t2_ready", 120'(bus.diy_ready), 120'd1);
      check("t2_rec",   120'(bus.recording), 120'd0);
      tap(1, 23'h00A000);
      check("t2_done_frozen", 120'(bus.diy_count), 120'd2);

      // 3: gap rule; exact MIN_GAP accepted; stop beats a same-cycle tap
      pulse_start();
      check("t3_ready_drop", 120'(bus.diy_ready), 120'd0);
      check("t3_cleared",    bus.diy_addresses, ALL_F_ADDR);
      check("t3_count0",     120'(bus.diy_count), 120'd0);
      tap(0, 23'h001000);
      tap(1, 23'h001400);
      check("t3_gap_reject", 120'(bus.diy_count), 120'd1);
      tap(1, 23'h001800);
      check("t3_gap_exact",  120'(bus.diy_count), 120'd2);
      bus.music_address = 23'h004000;
      bus.hole_buttons  = 9'b000001000;
      bus.record_stop   = 1'b1;
      tick();
      bus.record_stop   = 1'b0;
      bus.hole_buttons  = 9'd0;
      tick();
      check("t3_stop_wins", 120'(bus.diy_count), 120'd2);
      check("t3_stop_rec",  120'(bus.recording), 120'd0);
      check("t3_addr",      bus.diy_addresses,
            {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h001800, 24'h001000});

      // 4: holes 3 and 5 together -> hole 3 only
      pulse_start();
      bus.music_address = 23'h002000;
      bus.hole_buttons  = 9'b000101000;
      tick();
      bus.hole_buttons  = 9'd0;
      tick();
      check("t4_count", 120'(bus.diy_count), 120'd1);
      check("t4_loc",   120'(bus.diy_locations), 120'(20'hFFFF3));
      check("t4_addr",  bus.diy_addresses,
            {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h002000});
      // button held across a restart does not capture until re-pressed
      bus.music_address = 23'h003000;
      bus.hole_buttons  = 9'b000010000;
      tick();
      check("t4_pre_restart", 120'(bus.diy_count), 120'd2);
      pulse_start();
      bus.music_address = 23'h004000;
      tick();
      tick();
      check("t4_held", 120'(bus.diy_count), 120'd0);
      bus.hole_buttons = 9'd0;
      tick();
      tap(4, 23'h005000);
      check("t4_repress", 120'(bus.diy_locations), 120'(20'hFFFF4));

      // 5: five taps fill the chart; DONE on the 5th edge
      pulse_start();
      tap(0, 23'h001000);
      tap(1, 23'h002000);
      tap(2, 23'h003000);
      tap(3, 23'h004000);
      bus.music_address = 23'h005000;
      bus.hole_buttons  = 9'b000010000;
      tick();
      check("t5_full_count", 120'(bus.diy_count), 120'd5);
      check("t5_full_rec",   120'(bus.recording), 120'd0);
      check("t5_full_ready", 120'(bus.diy_ready), 120'd1);
      bus.hole_buttons = 9'd0;
      tick();
      tap(5, 23'h006000);
      check("t5_sixth", 120'(bus.diy_count), 120'd5);
      check("t5_addr",  bus.diy_addresses,
            {24'h005000, 24'h004000, 24'h003000, 24'h002000, 24'h001000});
      check("t5_loc",   120'(bus.diy_locations), 120'(20'h43210));

      // 6: song wrap ends capture (or, with undo, nothing to wrap against)
      pulse_start();
      tap(6, 23'h009000);
      check("t6_cap", 120'(bus.diy_count), 120'd1);
`ifdef DIY_UNDO_EN
      bus.undo = 1'b1;
      tick();
      bus.undo = 1'b0;
      check("t6_undo_count", 120'(bus.diy_count), 120'd0);
      check("t6_undo_addr",  bus.diy_addresses, ALL_F_ADDR);
      check("t6_undo_loc",   120'(bus.diy_locations), ALL_F_LOC);
      bus.music_address = 23'h000010;
      tick();
      check("t6_no_wrap", 120'(bus.recording), 120'd1);
      pulse_stop();
      check("t6_ready0",  120'(bus.diy_ready), 120'd0);
      check("t6_rec0",    120'(bus.recording), 120'd0);
`else
      bus.music_address = 23'h000010;
      tick();
      check("t6_wrap_rec",   120'(bus.recording), 120'd0);
      check("t6_wrap_count", 120'(bus.diy_count), 120'd1);
      check("t6_wrap_ready", 120'(bus.diy_ready), 120'd1);
      check("t6_wrap_loc",   120'(bus.diy_locations), 120'(20'hFFFF6));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
